// File: rtl/dmem.sv
// ============================================================================
//  Module   : dmem
//  Purpose  : 1 KiB byte-addressed data memory with 4-byte little-endian
//             access and a self-clearing start-up sequence after reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] valM_o,
    output logic        dmem_error,
    output logic        mem_busy
);

    localparam int unsigned   c_MEM_BYTES = 1024;
    localparam logic [31:0]   c_LAST_WORD = 32'h0000_03FC;
    localparam logic [0:0]    S_CLEAR     = 1'b0;
    localparam logic [0:0]    S_READY     = 1'b1;

    logic [7:0] r_mem [0:c_MEM_BYTES-1];
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_clr_cnt;
    logic [7:0] w_clr_cnt_nxt;

    logic        w_busy;
    logic        w_addr_valid;
    logic [9:0]  w_a0;
    logic [9:0]  w_a1;
    logic [9:0]  w_a2;
    logic [9:0]  w_a3;
    logic        w_req_wr;
    logic        w_req_rd;
    logic        w_we;
    logic [9:0]  w_wr_base;
    logic [31:0] w_wr_data;

    assign w_busy       = (r_state == S_CLEAR);
    assign w_addr_valid = (mem_addr <= c_LAST_WORD);

    // Byte indices are forced to zero for invalid addresses so no wrap is possible.
    assign w_a0 = w_addr_valid ? mem_addr[9:0] : 10'd0;
    assign w_a1 = w_addr_valid ? (w_a0 + 10'd1) : 10'd0;
    assign w_a2 = w_addr_valid ? (w_a0 + 10'd2) : 10'd0;
    assign w_a3 = w_addr_valid ? (w_a0 + 10'd3) : 10'd0;

    assign w_req_wr = !w_busy && mem_write && !mem_read && w_addr_valid;
    assign w_req_rd = !w_busy && mem_read && !mem_write && w_addr_valid;

    // Clearing and request writes share one 4-byte write port.
    assign w_we      = w_busy || w_req_wr;
    assign w_wr_base = w_busy ? {r_clr_cnt, 2'b00} : w_a0;
    assign w_wr_data = w_busy ? 32'h0000_0000 : mem_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 8'd1;
                if (r_clr_cnt == 8'd255) begin
                    w_state_nxt = S_READY;
                end
            end
            default: begin
                w_state_nxt   = S_READY;
                w_clr_cnt_nxt = r_clr_cnt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_wr_base]         <= w_wr_data[7:0];
            r_mem[w_wr_base + 10'd1] <= w_wr_data[15:8];
            r_mem[w_wr_base + 10'd2] <= w_wr_data[23:16];
            r_mem[w_wr_base + 10'd3] <= w_wr_data[31:24];
        end
    end

    always_comb begin
        valM_o     = 32'h0000_0000;
        dmem_error = 1'b0;
        if (w_req_rd) begin
            valM_o = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
        end
        if (!w_busy) begin
            dmem_error = ((mem_read || mem_write) && !w_addr_valid) ||
                         (mem_read && mem_write);
        end
    end

    assign mem_busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_dmem.sv
// ============================================================================
//  Module   : tb_dmem
//  Purpose  : Directed self-checking bench for dmem.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] valM_o;
    logic        dmem_error;
    logic        mem_busy;

    int n_assert;
    int n_fail;
    int busy_cycles;

    dmem u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .valM_o     (valM_o),
        .dmem_error (dmem_error),
        .mem_busy   (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_data  = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy();
        busy_cycles = 0;
        while (mem_busy && busy_cycles < 1000) begin
            tick();
            busy_cycles++;
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_data  = 32'h0;

        // Reset edge, then requests during CLEAR must be ignored
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_03FD, 32'h0);
        check("busy_after_reset", {31'd0, mem_busy}, 32'd1);
        check("valm_in_clear",    valM_o, 32'h0);
        check("err_in_clear",     {31'd0, dmem_error}, 32'd0);

        drive(1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA);
        check("err_write_in_clear", {31'd0, dmem_error}, 32'd0);
        count_busy();
        check("busy_len_first", busy_cycles, 32'd256);

        drive(1'b1, 1'b0, 32'h0000_03FC, 32'h0);
        check("rd_3fc_after_clear", valM_o, 32'h0);
        check("err_3fc_after_clear", {31'd0, dmem_error}, 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        check("rd_20_ignored_write", valM_o, 32'h0);

        // Basic write and unaligned reads
        drive(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678);
        check("err_valid_write", {31'd0, dmem_error}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        check("rd_100", valM_o, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h0000_0101, 32'h0);
        check("rd_101", valM_o, 32'h0012_3456);
        drive(1'b1, 1'b0, 32'h0000_00FF, 32'h0);
        check("rd_0ff", valM_o, 32'h3456_7800);

        // Out-of-range accesses
        drive(1'b1, 1'b0, 32'h0000_03FD, 32'h0);
        check("err_rd_3fd", {31'd0, dmem_error}, 32'd1);
        check("valm_rd_3fd", valM_o, 32'h0);
        drive(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF);
        check("err_wr_400", {31'd0, dmem_error}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        check("err_wr_ffffffff", {31'd0, dmem_error}, 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h0000_03FC, 32'h0);
        check("rd_3fc_untouched", valM_o, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        check("rd_000_no_wrap", valM_o, 32'h0);

        // Highest valid word
        drive(1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 1'b0, 32'h0000_03FC, 32'h0);
        check("rd_3fc_written", valM_o, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h0000_03FE, 32'h0);
        check("rd_3fe_invalid", valM_o, 32'h0);

        // Simultaneous read and write
        drive(1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
        check("err_rd_wr", {31'd0, dmem_error}, 32'd1);
        check("valm_rd_wr", valM_o, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        check("rd_100_unchanged", valM_o, 32'h1234_5678);

        // Idle with an out-of-range address is not an error
        drive(1'b0, 1'b0, 32'h0000_0400, 32'h0);
        check("err_idle", {31'd0, dmem_error}, 32'd0);
        check("valm_idle", valM_o, 32'h0);

        // Reset from READY, then again mid-clear at clr_cnt = 100
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("busy_reset_ready", {31'd0, mem_busy}, 32'd1);
        repeat (100) @(posedge clk);
        #1;
        check("busy_at_cnt100", {31'd0, mem_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("busy_after_mid_reset", {31'd0, mem_busy}, 32'd1);
        count_busy();
        check("busy_len_mid_reset", busy_cycles, 32'd256);
        drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        check("rd_100_recleared", valM_o, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_03FC, 32'h0);
        check("rd_3fc_recleared", valM_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
